// File: rtl/bus_arbiter4_pkg.sv
// Shared state encodings, requester count and the round-robin winner search
// for the four-master bus arbiter.
package bus_arbiter4_pkg;

  localparam int unsigned ARB_NREQ = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Returns {found, index}; search starts at ptr and wraps modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [2:0] res;
    res = '0;
    for (int unsigned i = 0; i < ARB_NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!res[2] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_arbiter4_mux4.sv
// Generic 4:1 payload multiplexer.
module mux4 #(
  parameter int width = 32
) (
  input  logic [1:0]       sel,
  input  logic [width-1:0] d0,
  input  logic [width-1:0] d1,
  input  logic [width-1:0] d2,
  input  logic [width-1:0] d3,
  output logic [width-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for four masters sharing one slave port; each grant is
// held until the slave pulses done or the hold timer expires.
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int width    = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             done,
  input  logic [width-1:0] d0,
  input  logic [width-1:0] d1,
  input  logic [width-1:0] d2,
  input  logic [width-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             timeout,
  output logic [width-1:0] y
);

  localparam int CW = $clog2(MAX_HOLD);

  arb_state_t    state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [2:0]    pick;
  logic          expired;

  always_comb pick = rr_pick(req, ptr);
  assign expired = (cnt == CW'(MAX_HOLD - 1));
  assign busy    = (state == ARB_GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      gnt     <= '0;
      sel     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == ARB_IDLE || done || expired) begin
        // done outranks the timer, so timeout only pulses on a pure expiry
        if (state == ARB_GRANT && !done) timeout <= 1'b1;
        if (pick[2]) begin
          state <= ARB_GRANT;
          gnt   <= 4'b0001 << pick[1:0];
          sel   <= pick[1:0];
          ptr   <= pick[1:0] + 2'd1;
          cnt   <= '0;
        end else begin
          state <= ARB_IDLE;
          gnt   <= '0;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  mux4 #(.width(width)) u_mux (
    .sel (sel),
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .y   (y)
  );

endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboard bench for bus_arbiter4: a driver pushes model expectations each
// cycle, a monitor pops and compares them after every rising edge.
module tb_bus_arbiter4;

  localparam int W  = 32;
  localparam int MH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0;
  logic          done = 1'b0;
  logic [W-1:0]  d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          busy;
  logic          timeout;
  logic [W-1:0]  y;

  bus_arbiter4 #(.width(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout), .y(y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         busy;
    logic         tmo;
    logic [W-1:0] y;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), rotating first-choice master,
  // and number of cycles the current owner has held the port.
  int owner = -1;
  int first = 0;
  int held  = 0;
  int last  = 0;
  logic [W-1:0] dv[4];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(first + k) % 4]) return (first + k) % 4;
    return -1;
  endfunction

  task automatic step(input logic [3:0] r, input logic dn, input logic rs);
    exp_t e;
    int   w;
    logic tmo;
    @(negedge clk);
    req = r; done = dn; rst = rs;
    d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    tmo = 1'b0;
    if (rs) begin
      owner = -1; first = 0; held = 0; last = 0;
      #1;
      chk("async_rst_gnt", W'(gnt), '0);
      chk("async_rst_sel", W'(sel), '0);
      chk("async_rst_y", y, d0);
    end else if (owner < 0 || dn || held + 1 == MH) begin
      if (owner >= 0 && !dn) tmo = 1'b1;
      w = winner(r);
      if (w >= 0) begin
        owner = w; last = w; first = (w + 1) % 4; held = 0;
      end else begin
        owner = -1;
      end
    end else begin
      held++;
    end
    e.gnt  = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
    e.sel  = 2'(last);
    e.busy = (owner >= 0);
    e.tmo  = tmo;
    e.y    = dv[last];
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("gnt", W'(gnt), W'(e.gnt));
      chk("sel", W'(sel), W'(e.sel));
      chk("busy", W'(busy), W'(e.busy));
      chk("timeout", W'(timeout), W'(e.tmo));
      chk("y", y, e.y);
    end
  end

  initial begin
    logic [3:0] r;
    logic       dn;
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    // single requester, then release
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // all requesting, done every third cycle: strict rotation, no gaps
    for (int i = 0; i < 15; i++) step(4'b1111, (i % 3) == 2, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // master 2 holds without done until the timer revokes it
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < MH + 3; i++) step(4'b0000, 1'b0, 1'b0);

    // done coincides with the final hold cycle
    step(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < MH - 1; i++) step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // owner drops req; another master waits for done
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // reset mid-grant, then pointer restarts at master 0
    step(4'b1001, 1'b0, 1'b1);
    step(4'b1001, 1'b0, 1'b0);
    step(4'b1001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // randomized traffic with varying done density
    for (int i = 0; i < 800; i++) begin
      r  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      if (i < 300)      dn = ($urandom_range(0, 3) == 0);
      else if (i < 600) dn = ($urandom_range(0, 24) == 0);
      else              dn = ($urandom_range(0, 1) == 0);
      step(r, dn, $urandom_range(0, 99) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
